// File: rtl/elevator_car_plant_if.sv
// Controller <-> car plant link: drive requests toward the plant, position/door feedback back.
interface elevator_car_plant_if #(
    parameter int N = 8
);
    logic         motor_up;
    logic         motor_down;
    logic         open_door;
    logic         close_door;
    logic [N-1:0] floor_sensor;
    logic         at_floor;
    logic         moving_up;
    logic         moving_down;
    logic         door_closed_sensor;
    logic         door_open_sensor;
    logic         fault_conflict;
    logic         fault_limit;
    logic         fault_door;

    modport master (
        output motor_up, motor_down, open_door, close_door,
        input  floor_sensor, at_floor, moving_up, moving_down,
               door_closed_sensor, door_open_sensor,
               fault_conflict, fault_limit, fault_door
    );

    modport slave (
        input  motor_up, motor_down, open_door, close_door,
        output floor_sensor, at_floor, moving_up, moving_down,
               door_closed_sensor, door_open_sensor,
               fault_conflict, fault_limit, fault_door
    );
endinterface

// File: rtl/elevator_car_plant.sv
// Plant model of one elevator car and door: turns motor/door drive requests into
// one-hot floor sensing and door position feedback, flagging illegal requests.
//
// state    | meaning
// M_IDLE   | no car step accepted on the last edge
// M_UP     | upward step accepted on the last edge
// M_DOWN   | downward step accepted on the last edge
// D_CLOSED | door_pos == 0
// D_OPENING| door partly open, last movement was opening
// D_OPEN   | door_pos == DOOR_TICKS
// D_CLOSING| door partly open, last movement was closing
module elevator_car_plant #(
    parameter int N               = 8,
    parameter int TICKS_PER_FLOOR = 4,
    parameter int DOOR_TICKS      = 3,
    parameter int INIT_FLOOR      = 0
) (
    input  logic               clk,
    input  logic               rst,
    elevator_car_plant_if.slave bus
);
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int OW = $clog2(TICKS_PER_FLOOR);
    localparam int DW = $clog2(DOOR_TICKS + 1);

    localparam logic [BW-1:0] BASE_TOP  = BW'(N - 1);
    localparam logic [BW-1:0] BASE_INIT = BW'(INIT_FLOOR);
    localparam logic [OW-1:0] OFF_TOP   = OW'(TICKS_PER_FLOOR - 1);
    localparam logic [DW-1:0] DOOR_FULL = DW'(DOOR_TICKS);
    localparam logic [N-1:0]  ONE_HOT0  = N'(1);

    typedef enum logic [1:0] {M_IDLE, M_UP, M_DOWN} motion_t;
    typedef enum logic [1:0] {D_CLOSED, D_OPENING, D_OPEN, D_CLOSING} door_t;

    motion_t       mstate, mstate_n;
    door_t         dstate, dstate_n;
    logic [BW-1:0] base, base_n, last_al, last_al_n;
    logic [OW-1:0] offset, offset_n;
    logic [DW-1:0] door_pos, door_pos_n;
    logic          f_conf, f_conf_n, f_lim, f_lim_n, f_door, f_door_n;

    logic any_motor, aligned, up_ok, down_ok, open_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            mstate   <= M_IDLE;
            dstate   <= D_CLOSED;
            base     <= BASE_INIT;
            last_al  <= BASE_INIT;
            offset   <= '0;
            door_pos <= '0;
            f_conf   <= 1'b0;
            f_lim    <= 1'b0;
            f_door   <= 1'b0;
        end else begin
            mstate   <= mstate_n;
            dstate   <= dstate_n;
            base     <= base_n;
            last_al  <= last_al_n;
            offset   <= offset_n;
            door_pos <= door_pos_n;
            f_conf   <= f_conf_n;
            f_lim    <= f_lim_n;
            f_door   <= f_door_n;
        end
    end

    always_comb begin
        base_n     = base;
        offset_n   = offset;
        last_al_n  = last_al;
        door_pos_n = door_pos;
        mstate_n   = M_IDLE;
        dstate_n   = dstate;

        any_motor = bus.motor_up | bus.motor_down;
        aligned   = (offset == '0);
        up_ok     = bus.motor_up & ~bus.motor_down & (door_pos == '0) & (base != BASE_TOP);
        down_ok   = bus.motor_down & ~bus.motor_up & (door_pos == '0) &
                    ~((base == '0) & aligned);
        open_ok   = bus.open_door & aligned & ~any_motor;

        if (up_ok) begin
            mstate_n = M_UP;
            if (offset == OFF_TOP) begin
                base_n   = base + BW'(1);
                offset_n = '0;
            end else begin
                offset_n = offset + OW'(1);
            end
        end else if (down_ok) begin
            mstate_n = M_DOWN;
            if (aligned) begin
                base_n   = base - BW'(1);
                offset_n = OFF_TOP;
            end else begin
                offset_n = offset - OW'(1);
            end
        end

        if (offset_n == '0)
            last_al_n = base_n;

        // open_door has priority over close_door even when it is itself rejected
        if (bus.open_door) begin
            if (open_ok && door_pos != DOOR_FULL)
                door_pos_n = door_pos + DW'(1);
        end else if (bus.close_door && door_pos != '0) begin
            door_pos_n = door_pos - DW'(1);
        end

        if (door_pos_n == '0)
            dstate_n = D_CLOSED;
        else if (door_pos_n == DOOR_FULL)
            dstate_n = D_OPEN;
        else if (door_pos_n > door_pos)
            dstate_n = D_OPENING;
        else if (door_pos_n < door_pos)
            dstate_n = D_CLOSING;

        f_conf_n = f_conf | (bus.motor_up & bus.motor_down) | (bus.open_door & bus.close_door);
        f_lim_n  = f_lim | (bus.motor_up & (base == BASE_TOP)) |
                   (bus.motor_down & (base == '0) & aligned);
        f_door_n = f_door | (any_motor & (door_pos != '0)) |
                   (bus.open_door & (~aligned | any_motor));
    end

    assign bus.floor_sensor       = ONE_HOT0 << last_al;
    assign bus.at_floor           = (offset == '0);
    assign bus.moving_up          = (mstate == M_UP);
    assign bus.moving_down        = (mstate == M_DOWN);
    assign bus.door_closed_sensor = (dstate == D_CLOSED);
    assign bus.door_open_sensor   = (dstate == D_OPEN);
    assign bus.fault_conflict     = f_conf;
    assign bus.fault_limit        = f_lim;
    assign bus.fault_door         = f_door;
endmodule
